// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: picks a random hole and up-time from the PRNG word, then judges hits, wrong hits and timeouts.
// Latency: every output is registered, so a decision made in a cycle appears one clock later.
// Backpressure: none. Inputs are sampled every cycle, and the one-cycle pulses are never held or queued.
module mole_scheduler #(
    parameter int N_HOLES    = 9,
    parameter int MIN_UP     = 16,
    parameter int MIN_GAP    = 4,
    parameter int MAX_REROLL = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [15:0]        random_i,
    input  logic               game_en_i,
    input  logic               tick_i,
    input  logic               hit_valid_i,
    input  logic [3:0]         hit_idx_i,
    output logic               mole_valid_o,
    output logic [3:0]         mole_idx_o,
    output logic [N_HOLES-1:0] mole_mask_o,
    output logic               hit_pulse_o,
    output logic               miss_pulse_o,
    output logic               wrong_pulse_o
);

    localparam int                 RW          = (MAX_REROLL > 1) ? $clog2(MAX_REROLL) : 1;
    localparam logic [4:0]         NH5         = 5'(N_HOLES);
    localparam logic [3:0]         LAST_HOLE   = 4'(N_HOLES - 1);
    localparam logic [RW-1:0]      LAST_REROLL = RW'(MAX_REROLL - 1);
    localparam logic [N_HOLES-1:0] ONE_HOT0    = {{(N_HOLES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_PICK, S_UP} state_e;

    state_e             state_q;
    logic [3:0]         last_idx_q;
    logic [7:0]         gap_cnt_q;
    logic [7:0]         up_cnt_q;
    logic [RW-1:0]      reroll_cnt_q;
    logic               mole_valid_q;
    logic [3:0]         mole_idx_q;
    logic [N_HOLES-1:0] mole_mask_q;
    logic               hit_pulse_q;
    logic               miss_pulse_q;
    logic               wrong_pulse_q;

    logic               cand_ok_d;
    logic [3:0]         fallback_d;
    logic [3:0]         pick_idx_d;
    logic               pick_take_d;
    logic [N_HOLES-1:0] mask_d;
    logic [7:0]         up_load_d;
    logic [7:0]         gap_load_d;
    logic               hit_match_d;

    // random[7:4] is not used by the game.
    logic unused_rand;
    assign unused_rand = ^random_i[7:4];

    // Candidate evaluation, fallback hole and timer reload values, all taken from this cycle's PRNG word.
    always_comb begin
        cand_ok_d   = ({1'b0, random_i[3:0]} < NH5) && (random_i[3:0] != last_idx_q);
        fallback_d  = (last_idx_q >= LAST_HOLE) ? 4'd0 : last_idx_q + 4'd1;
        pick_idx_d  = cand_ok_d ? random_i[3:0] : fallback_d;
        // The last permitted rejection is turned into an accept of the fallback hole.
        pick_take_d = cand_ok_d || (reroll_cnt_q == LAST_REROLL);
        mask_d      = ONE_HOT0 << pick_idx_d;
        up_load_d   = 8'(MIN_UP) + {2'b00, random_i[15:10]};
        gap_load_d  = 8'(MIN_GAP) + {6'd0, random_i[9:8]};
        hit_match_d = hit_valid_i && (hit_idx_i == mole_idx_q);
    end

    // Game FSM with registered outputs. Pulses default to 0 and are set for exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            last_idx_q    <= 4'hF;
            gap_cnt_q     <= 8'd0;
            up_cnt_q      <= 8'd0;
            reroll_cnt_q  <= '0;
            mole_valid_q  <= 1'b0;
            mole_idx_q    <= 4'd0;
            mole_mask_q   <= '0;
            hit_pulse_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            wrong_pulse_q <= 1'b0;
        end else begin
            hit_pulse_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            wrong_pulse_q <= 1'b0;
            if (!game_en_i) begin
                // Disabling drops any mole silently. last_idx survives, so the next game never repeats the hole.
                state_q      <= S_IDLE;
                gap_cnt_q    <= 8'd0;
                up_cnt_q     <= 8'd0;
                reroll_cnt_q <= '0;
                mole_valid_q <= 1'b0;
                mole_idx_q   <= 4'd0;
                mole_mask_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        gap_cnt_q <= 8'(MIN_GAP);
                        state_q   <= S_GAP;
                    end
                    S_GAP: begin
                        if (tick_i) begin
                            gap_cnt_q <= gap_cnt_q - 8'd1;
                            if (gap_cnt_q == 8'd1) begin
                                state_q <= S_PICK;
                            end
                        end
                    end
                    S_PICK: begin
                        if (pick_take_d) begin
                            mole_idx_q   <= pick_idx_d;
                            last_idx_q   <= pick_idx_d;
                            mole_valid_q <= 1'b1;
                            mole_mask_q  <= mask_d;
                            up_cnt_q     <= up_load_d;
                            reroll_cnt_q <= '0;
                            state_q      <= S_UP;
                        end else begin
                            reroll_cnt_q <= reroll_cnt_q + RW'(1);
                        end
                    end
                    S_UP: begin
                        // Priority: a matching hit beats the final tick, and a timeout beats a wrong hit.
                        if (hit_match_d || (tick_i && up_cnt_q == 8'd1)) begin
                            hit_pulse_q  <= hit_match_d;
                            miss_pulse_q <= !hit_match_d;
                            mole_valid_q <= 1'b0;
                            mole_idx_q   <= 4'd0;
                            mole_mask_q  <= '0;
                            up_cnt_q     <= 8'd0;
                            gap_cnt_q    <= gap_load_d;
                            state_q      <= S_GAP;
                        end else begin
                            wrong_pulse_q <= hit_valid_i;
                            if (tick_i) begin
                                up_cnt_q <= up_cnt_q - 8'd1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign mole_valid_o  = mole_valid_q;
    assign mole_idx_o    = mole_idx_q;
    assign mole_mask_o   = mole_mask_q;
    assign hit_pulse_o   = hit_pulse_q;
    assign miss_pulse_o  = miss_pulse_q;
    assign wrong_pulse_o = wrong_pulse_q;

endmodule
